// File: rtl/uart_pkg.sv
// Shared constants and types for the UART sample path and the UART hex-print controller.
// Also holds the saturating-increment helper used by the drop counter.
package uart_pkg;

   localparam int UART_DATA_W = 16;
   localparam int OVF_W       = 16;
   localparam int DEC_W       = 8;

   typedef logic [OVF_W-1:0] ovf_t;
   typedef logic [DEC_W-1:0] dec_t;

   // Saturates at all-ones so a long stall never wraps the drop count back to a small value.
   function automatic ovf_t ovf_sat_inc(input ovf_t cnt);
      return (cnt == '1) ? cnt : cnt + ovf_t'(1);
   endfunction

endpackage

// File: rtl/uart_sample_queue_if.sv
// Producer/consumer bundle of the sample queue: sample strobe, flush, FWFT output handshake and status.
interface uart_sample_queue_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   localparam int LVL_W = $clog2(DEPTH) + 1
);

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              flush;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [LVL_W-1:0]  level;
   logic [15:0]       overflow_cnt;

   modport master (
      output in_data, in_valid, flush, out_ready,
      input  out_data, out_valid, level, overflow_cnt
   );

   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output out_data, out_valid, level, overflow_cnt
   );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: head entry is held in a register and
// out-of-band full/empty are derived from a registered level, not pointer equality.
module sync_fifo_fwft #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              valid,
   output logic              full,
   output logic [LVL_W-1:0]  level
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_nxt;
   logic              pop_ok;
   logic              push_ok;

   assign valid = (level != '0);
   assign full  = (level == LVL_W'(DEPTH));

   always_comb begin
      pop_ok  = pop && valid;
      push_ok = push && (!full || pop_ok);
      rd_nxt  = rd_ptr + PTR_W'(1);
   end

   // Storage carries no reset; only pointers and level define what is live.
   always_ff @(posedge clk) begin
      if (push_ok && !clr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         rd_data <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_nxt;

         case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase

         // Refill the head register: from storage when a successor exists, else straight from the write port.
         if (pop_ok) begin
            if (level > LVL_W'(1)) begin
               rd_data <= mem[rd_nxt];
            end else if (push_ok) begin
               rd_data <= wr_data;
            end
         end else if (push_ok && !valid) begin
            rd_data <= wr_data;
         end
      end
   end

endmodule

// File: rtl/uart_sample_queue.sv
// Sample buffer in front of the UART hex printer: decimates producer strobes, drops and
// counts samples that find the queue full, and supports a synchronous flush.
module uart_sample_queue
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = UART_DATA_W,
   parameter int DECIM  = 1
) (
   input  logic                clk,
   input  logic                rst,
   uart_sample_queue_if.slave  q
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   dec_t             dec_cnt;
   ovf_t             ovf_cnt;
   logic             candidate;
   logic             pop_req;
   logic             will_pop;
   logic             fifo_full;
   logic             drop;

   always_comb begin
      candidate = q.in_valid && (dec_cnt == '0) && !q.flush;
      pop_req   = q.out_ready && !q.flush;
      will_pop  = pop_req && q.out_valid;
      drop      = candidate && fifo_full && !will_pop;
   end

   // Phase counter advances on every strobe; only phase 0 is offered to the queue.
   always_ff @(posedge clk) begin
      if (rst || q.flush) begin
         dec_cnt <= '0;
      end else if (q.in_valid) begin
         dec_cnt <= (dec_cnt == dec_t'(DECIM - 1)) ? '0 : dec_cnt + dec_t'(1);
      end
   end

   // Flush deliberately leaves the drop count alone so lost data stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt <= '0;
      end else if (drop) begin
         ovf_cnt <= ovf_sat_inc(ovf_cnt);
      end
   end

   assign q.overflow_cnt = ovf_cnt;

   sync_fifo_fwft #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (q.flush),
      .push    (candidate),
      .wr_data (q.in_data),
      .pop     (pop_req),
      .rd_data (q.out_data),
      .valid   (q.out_valid),
      .full    (fifo_full),
      .level   (q.level)
   );

   logic [LVL_W-1:0] unused_level;
   assign unused_level = q.level;

endmodule

// File: tb/tb_uart_sample_queue.sv
// Directed bench for uart_sample_queue: one instance without decimation, one with DECIM=3.
module tb_uart_sample_queue;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   uart_sample_queue_if #(.DATA_W(16), .DEPTH(16)) qa ();
   uart_sample_queue_if #(.DATA_W(16), .DEPTH(16)) qb ();

   uart_sample_queue #(.DEPTH(16), .DATA_W(16), .DECIM(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .q   (qa.slave)
   );

   uart_sample_queue #(.DEPTH(16), .DATA_W(16), .DECIM(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .q   (qb.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      qa.in_valid = 1'b0; qa.flush = 1'b0; qa.out_ready = 1'b0; qa.in_data = '0;
      qb.in_valid = 1'b0; qb.flush = 1'b0; qb.out_ready = 1'b0; qb.in_data = '0;
   endtask

   initial begin
      idle_all();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_valid", 32'(qa.out_valid), 32'd0);
      check("rst_level", 32'(qa.level), 32'd0);
      check("rst_ovf",   32'(qa.overflow_cnt), 32'd0);
      check("rst_data",  32'(qa.out_data), 32'd0);
      check("rst_b_lvl", 32'(qb.level), 32'd0);

      // Basic pass-through with consumer always ready
      qa.out_ready = 1'b1;
      qa.in_valid = 1'b1; qa.in_data = 16'h1234;
      tick();
      check("basic_valid1", 32'(qa.out_valid), 32'd1);
      check("basic_data1",  32'(qa.out_data), 32'h1234);
      qa.in_data = 16'hABCD;
      tick();
      qa.in_valid = 1'b0;
      check("basic_data2",  32'(qa.out_data), 32'hABCD);
      check("basic_lvl2",   32'(qa.level), 32'd1);
      tick();
      check("basic_empty",  32'(qa.out_valid), 32'd0);
      check("basic_lvl0",   32'(qa.level), 32'd0);
      qa.out_ready = 1'b0;

      // Overflow: 20 pushes into 16 entries
      for (int i = 0; i < 20; i++) begin
         qa.in_valid = 1'b1; qa.in_data = 16'(i);
         tick();
      end
      qa.in_valid = 1'b0;
      check("ovf_level", 32'(qa.level), 32'd16);
      check("ovf_cnt",   32'(qa.overflow_cnt), 32'd4);
      qa.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("ovf_drain_v", 32'(qa.out_valid), 32'd1);
         check("ovf_drain_d", 32'(qa.out_data), 32'(i));
         tick();
      end
      qa.out_ready = 1'b0;
      check("ovf_drained", 32'(qa.level), 32'd0);

      // Full queue, push in the same cycle as a pop
      for (int i = 0; i < 16; i++) begin
         qa.in_valid = 1'b1; qa.in_data = 16'(16'h100 + i);
         tick();
      end
      qa.in_valid = 1'b1; qa.in_data = 16'h00FF; qa.out_ready = 1'b1;
      tick();
      qa.in_valid = 1'b0; qa.out_ready = 1'b0;
      check("fullpop_lvl", 32'(qa.level), 32'd16);
      check("fullpop_ovf", 32'(qa.overflow_cnt), 32'd4);
      qa.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("fullpop_d", 32'(qa.out_data), (i < 15) ? 32'(32'h101 + i) : 32'h00FF);
         tick();
      end
      qa.out_ready = 1'b0;
      check("fullpop_end", 32'(qa.out_valid), 32'd0);

      // Flush with concurrent strobe and ready
      for (int i = 0; i < 5; i++) begin
         qa.in_valid = 1'b1; qa.in_data = 16'(16'h50 + i);
         tick();
      end
      qa.in_valid = 1'b0;
      check("flush_pre_lvl", 32'(qa.level), 32'd5);
      qa.flush = 1'b1; qa.in_valid = 1'b1; qa.in_data = 16'h5555; qa.out_ready = 1'b1;
      tick();
      qa.flush = 1'b0; qa.in_valid = 1'b0; qa.out_ready = 1'b0;
      check("flush_lvl",   32'(qa.level), 32'd0);
      check("flush_valid", 32'(qa.out_valid), 32'd0);
      check("flush_ovf",   32'(qa.overflow_cnt), 32'd4);
      qa.in_valid = 1'b1; qa.in_data = 16'h0077;
      tick();
      qa.in_valid = 1'b0;
      check("flush_next_d", 32'(qa.out_data), 32'h0077);
      check("flush_next_l", 32'(qa.level), 32'd1);
      qa.out_ready = 1'b1;
      tick();
      qa.out_ready = 1'b0;
      check("flush_clean", 32'(qa.level), 32'd0);

      // Decimation by 3 on the second instance
      for (int i = 1; i <= 9; i++) begin
         qb.in_valid = 1'b1; qb.in_data = 16'(i);
         tick();
      end
      qb.in_valid = 1'b0;
      check("dec_level", 32'(qb.level), 32'd3);
      check("dec_ovf",   32'(qb.overflow_cnt), 32'd0);
      qb.out_ready = 1'b1;
      check("dec_d0", 32'(qb.out_data), 32'd1);
      tick();
      check("dec_d1", 32'(qb.out_data), 32'd4);
      tick();
      check("dec_d2", 32'(qb.out_data), 32'd7);
      tick();
      qb.out_ready = 1'b0;
      check("dec_empty", 32'(qb.out_valid), 32'd0);
      // Flush must restart the decimation phase
      qb.in_valid = 1'b1; qb.in_data = 16'd10;
      tick();
      qb.in_valid = 1'b0; qb.flush = 1'b1;
      tick();
      qb.flush = 1'b0; qb.in_valid = 1'b1; qb.in_data = 16'd11;
      tick();
      qb.in_valid = 1'b0;
      check("dec_flush_lvl", 32'(qb.level), 32'd1);
      check("dec_flush_d",   32'(qb.out_data), 32'd11);

      // Reset mid-stream with a strobe present
      for (int i = 0; i < 8; i++) begin
         qa.in_valid = 1'b1; qa.in_data = 16'(16'h200 + i);
         tick();
      end
      qa.in_valid = 1'b0;
      check("mid_pre_lvl", 32'(qa.level), 32'd8);
      rst = 1'b1; qa.in_valid = 1'b1; qa.in_data = 16'hEEEE;
      tick();
      rst = 1'b0; qa.in_valid = 1'b0;
      check("mid_lvl",   32'(qa.level), 32'd0);
      check("mid_valid", 32'(qa.out_valid), 32'd0);
      check("mid_data",  32'(qa.out_data), 32'd0);
      check("mid_ovf",   32'(qa.overflow_cnt), 32'd0);
      qa.in_valid = 1'b1; qa.in_data = 16'h4242;
      tick();
      qa.in_valid = 1'b0;
      check("mid_push_v", 32'(qa.out_valid), 32'd1);
      check("mid_push_d", 32'(qa.out_data), 32'h4242);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_sample_queue.md
Name: uart_sample_queue

Overview:
- Upstream feeder for the UART hex-print controller: buffers 16-bit samples from a producer that cannot be stalled, and presents them one at a time over a valid/ready handshake.
- Producer: sensor/ADC capture logic, single-cycle in_valid pulses, no backpressure.
- Consumer: the UART controller, which latches out_data on the cycle out_valid && out_ready and is busy for many cycles per word.
- Adds optional decimation, flush and overflow accounting so slow UART output never corrupts the sample stream.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- DATA_W, 16, sample width; must match consumer data width.
- DECIM, 1, forward every DECIM-th input sample; range 1..255; 1 = no decimation.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  DATA_W  sample from producer
- in_valid  input  1  single-cycle strobe, in_data valid this cycle
- flush  input  1  synchronous clear of queued data and decimation phase
- out_data  output  DATA_W  head-of-queue sample
- out_valid  output  1  out_data holds a valid sample
- out_ready  input  1  consumer accepts out_data this cycle
- level  output  $clog2(DEPTH)+1  entries currently stored
- overflow_cnt  output  16  count of dropped samples, saturating at 16'hFFFF

Behaviour:
- Reset (rst=1 at clk edge): FIFO emptied; out_valid=0, out_data=0, level=0, overflow_cnt=0, decimation counter=0. in_valid is ignored while rst=1.
- Decimation:
  - dec_cnt counts in_valid strobes from 0 to DECIM-1, then wraps to 0.
  - A strobe is a candidate push only when dec_cnt==0 at that strobe.
  - Non-candidate strobes are discarded silently and never counted as overflow.
- Push: a candidate is written when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle. Otherwise it is dropped and overflow_cnt increments, saturating at 16'hFFFF.
- Pop: occurs when out_valid && out_ready; the head entry is removed that cycle.
- Output (first-word-fall-through, registered):
  - out_valid=1 iff level>0.
  - out_data equals the head entry and holds stable while out_valid=1 and no pop occurs.
  - When out_valid=0, out_data holds its last value; it is not required to be zero.
- Latency:
  - A push into an empty queue raises out_valid on the next cycle, with that sample on out_data.
  - After a pop, the next entry appears on the following cycle.
  - Back-to-back pops on consecutive cycles are supported; throughput is 1 word/cycle.
- Simultaneous push and pop: level is unchanged, and data order is preserved (strict FIFO).
- level: updated on the cycle after a push/pop, i.e. a registered count; width covers 0..DEPTH inclusive.
- Pointers: read/write pointers wrap modulo DEPTH; full/empty are decided from level, never from pointer equality alone.
- Flush (highest priority below rst):
  - Next cycle: level=0, out_valid=0, dec_cnt=0.
  - Any in_valid or pop in the flush cycle is discarded; a strobe in that cycle does not increment overflow_cnt.
  - overflow_cnt is preserved; only rst clears it.
- out_ready while out_valid=0: ignored, no pop.
- Control: no explicit FSM. Behaviour is set by the level register, wr_ptr/rd_ptr, dec_cnt and the overflow counter, with priority rst > flush > push/pop.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W = 16, the common word width for this block and the UART controller.
  - The overflow counter width constant OVF_W = 16.
- One natural sub-module: sync_fifo_fwft, a parameterised storage array with pointers, level and registered head output.
- uart_sample_queue adds decimation, the drop/overflow policy and flush priority on top of sync_fifo_fwft.

Test Plan:
- Basic, DECIM=1: push 16'h1234, 16'hABCD with out_ready=1 -> out_valid rises 1 cycle after the first push; consumer sees 16'h1234 then 16'hABCD; level returns to 0.
- Overflow, DEPTH=16, out_ready=0: push 20 samples 0..19 -> level=16, overflow_cnt=4; after draining, outputs are exactly 0..15 in order.
- Full with simultaneous pop: level=16, push 16'h00FF in the same cycle as out_ready=1 -> no drop, overflow_cnt unchanged, level stays 16, 16'h00FF is the last word out.
- Decimation, DECIM=3: strobes with data 1..9 -> queue receives 1, 4, 7 only; overflow_cnt=0.
- Flush: level=5, assert flush together with in_valid (data 16'h5555) and out_ready=1 -> next cycle level=0, out_valid=0; 16'h5555 is never output; overflow_cnt unchanged.
- Reset mid-stream: level=8, overflow_cnt=3, assert rst for 1 cycle with in_valid=1 -> next cycle level=0, out_valid=0, out_data=0, overflow_cnt=0; the first push after reset appears 1 cycle later.
